// File: rtl/video_timing_pkg.sv
// Shared timing constants and helpers for the raster timing generator.
// Covers the standard 1080p60 and 720p60 modes.
package video_timing_pkg;

    localparam int unsigned p1080HActive = 32'd1920;
    localparam int unsigned p1080HFront  = 32'd88;
    localparam int unsigned p1080HSyncW  = 32'd44;
    localparam int unsigned p1080HBack   = 32'd148;
    localparam int unsigned p1080VActive = 32'd1080;
    localparam int unsigned p1080VFront  = 32'd4;
    localparam int unsigned p1080VSyncW  = 32'd5;
    localparam int unsigned p1080VBack   = 32'd36;

    localparam int unsigned p720HActive  = 32'd1280;
    localparam int unsigned p720HFront   = 32'd110;
    localparam int unsigned p720HSyncW   = 32'd40;
    localparam int unsigned p720HBack    = 32'd220;
    localparam int unsigned p720VActive  = 32'd720;
    localparam int unsigned p720VFront   = 32'd5;
    localparam int unsigned p720VSyncW   = 32'd5;
    localparam int unsigned p720VBack    = 32'd20;

    // Decoded per-pixel flags, registered together so they always describe one pixel.
    typedef struct packed {
        logic de;
        logic hSync;
        logic vSync;
        logic lineStart;
        logic frameStart;
    } pixelFlags_t;

    function automatic int unsigned calcTotal(input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned syncW,
                                              input int unsigned back);
        return active + front + syncW + back;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter with wrap plus active/sync/zero decode
// of the currently held position.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned busWidth = 32'd12,
    parameter int unsigned active   = 32'd8,
    parameter int unsigned front    = 32'd2,
    parameter int unsigned syncW    = 32'd3,
    parameter int unsigned back     = 32'd2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    output logic [busWidth-1:0] pos,
    output logic                wrap,
    output logic                inActive,
    output logic                inSync,
    output logic                atZero
);

    localparam int unsigned total = calcTotal(active, front, syncW, back);
    localparam logic [busWidth-1:0] lastPos   = busWidth'(total - 32'd1);
    localparam logic [busWidth-1:0] activeEnd = busWidth'(active);
    localparam logic [busWidth-1:0] syncStart = busWidth'(active + front);
    localparam logic [busWidth-1:0] syncEnd   = busWidth'(active + front + syncW - 32'd1);

    if (front == 32'd0 || syncW == 32'd0 || back == 32'd0) begin : gBadAxis
        $error("timing_axis_counter: porch and sync widths must be non-zero");
    end

    logic [busWidth-1:0] pos_r;
    logic                wrap_s;
    logic                inActive_s;
    logic                inSync_s;
    logic                atZero_s;

    // Bounds are constants, so the decode is pure comparisons against pos_r.
    always_comb begin
        wrap_s     = (pos_r == lastPos);
        inActive_s = (pos_r < activeEnd);
        inSync_s   = (pos_r >= syncStart) && (pos_r <= syncEnd);
        atZero_s   = (pos_r == {busWidth{1'b0}});
    end

    // Position counter; wraps to zero after the last position of the axis.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_r <= {busWidth{1'b0}};
        end else if (advance) begin
            pos_r <= wrap_s ? {busWidth{1'b0}} : pos_r + busWidth'(1);
        end
    end

    assign pos      = pos_r;
    assign wrap     = wrap_s;
    assign inActive = inActive_s;
    assign inSync   = inSync_s;
    assign atZero   = atZero_s;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, DE, coordinates and line/frame markers,
// all registered with one cycle of latency from the internal counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned busWidth = 32'd12,
    parameter int unsigned hActive  = 32'd1920,
    parameter int unsigned hFront   = 32'd88,
    parameter int unsigned hSyncW   = 32'd44,
    parameter int unsigned hBack    = 32'd148,
    parameter int unsigned vActive  = 32'd1080,
    parameter int unsigned vFront   = 32'd4,
    parameter int unsigned vSyncW   = 32'd5,
    parameter int unsigned vBack    = 32'd36,
    parameter bit          hSyncPol = 1'b1,
    parameter bit          vSyncPol = 1'b1
) (
    input  logic                pixelClk,
    input  logic                reset,
    input  logic                enable,
    output logic                hSync,
    output logic                vSync,
    output logic                deOut,
    output logic [busWidth-1:0] hCount,
    output logic [busWidth-1:0] vCount,
    output logic                lineStart,
    output logic                frameStart
);

    if (longint'(calcTotal(hActive, hFront, hSyncW, hBack)) > (longint'(1) << busWidth) ||
        longint'(calcTotal(vActive, vFront, vSyncW, vBack)) > (longint'(1) << busWidth)) begin : gBadTotal
        $error("video_timing_gen: raster total does not fit in busWidth");
    end

    logic [busWidth-1:0] hPos_s;
    logic [busWidth-1:0] vPos_s;
    logic                hWrap_s;
    logic                unusedVWrap_s;
    logic                hInActive_s;
    logic                hInSync_s;
    logic                hAtZero_s;
    logic                vInActive_s;
    logic                vInSync_s;
    logic                vAtZero_s;
    logic                vAdvance_s;

    pixelFlags_t         flagsNext_s;
    pixelFlags_t         flags_r;
    logic [busWidth-1:0] hCount_r;
    logic [busWidth-1:0] vCount_r;

    assign vAdvance_s = hWrap_s & enable;

    timing_axis_counter #(
        .busWidth(busWidth), .active(hActive), .front(hFront), .syncW(hSyncW), .back(hBack)
    ) uHAxis (
        .clk(pixelClk), .reset(reset), .advance(enable),
        .pos(hPos_s), .wrap(hWrap_s),
        .inActive(hInActive_s), .inSync(hInSync_s), .atZero(hAtZero_s)
    );

    timing_axis_counter #(
        .busWidth(busWidth), .active(vActive), .front(vFront), .syncW(vSyncW), .back(vBack)
    ) uVAxis (
        .clk(pixelClk), .reset(reset), .advance(vAdvance_s),
        .pos(vPos_s), .wrap(unusedVWrap_s),
        .inActive(vInActive_s), .inSync(vInSync_s), .atZero(vAtZero_s)
    );

    // Combine the axis decodes into the flags for the pixel the counters hold now.
    always_comb begin
        flagsNext_s.de         = hInActive_s & vInActive_s;
        flagsNext_s.hSync      = hInSync_s ? hSyncPol : ~hSyncPol;
        flagsNext_s.vSync      = vInSync_s ? vSyncPol : ~vSyncPol;
        flagsNext_s.lineStart  = hAtZero_s;
        flagsNext_s.frameStart = hAtZero_s & vAtZero_s;
    end

    // Output stage: coordinates and flags move together so they never skew.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            hCount_r <= {busWidth{1'b0}};
            vCount_r <= {busWidth{1'b0}};
            flags_r  <= '{de: 1'b0, hSync: ~hSyncPol, vSync: ~vSyncPol,
                          lineStart: 1'b0, frameStart: 1'b0};
        end else if (enable) begin
            hCount_r <= hPos_s;
            vCount_r <= vPos_s;
            flags_r  <= flagsNext_s;
        end
    end

    assign hCount     = hCount_r;
    assign vCount     = vCount_r;
    assign deOut      = flags_r.de;
    assign hSync      = flags_r.hSync;
    assign vSync      = flags_r.vSync;
    assign lineStart  = flags_r.lineStart;
    assign frameStart = flags_r.frameStart;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the HDMI overlay pipeline, replacing the old DE block that only counted horizontally and had no sync or vertical gating. It runs on the pixel clock. It produces hSync, vSync and a DE that is gated both horizontally and vertically. It also outputs coherent pixel coordinates and line/frame markers, which drive the overlay compositor and the TMDS encoder.

Parameters:
busWidth, 12, width of the hCount/vCount buses and internal counters
hActive, 1920, active pixels per line
hFront, 88, horizontal front porch, in pixels
hSyncW, 44, horizontal sync width, in pixels
hBack, 148, horizontal back porch, in pixels
vActive, 1080, active lines per frame
vFront, 4, vertical front porch, in lines
vSyncW, 5, vertical sync width, in lines
vBack, 36, vertical back porch, in lines
hSyncPol, 1, 1 = sync asserted high, 0 = asserted low
vSyncPol, 1, 1 = sync asserted high, 0 = asserted low

Ports:
pixelClk  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  clock enable; when low, all state holds
hSync  out  1  horizontal sync, polarity per hSyncPol
vSync  out  1  vertical sync, polarity per vSyncPol
deOut  out  1  data enable; high only inside the active area
hCount  out  busWidth  horizontal position of the presented pixel
vCount  out  busWidth  vertical position of the presented pixel
lineStart  out  1  one-cycle pulse when hCount==0
frameStart  out  1  one-cycle pulse when hCount==0 and vCount==0

Behaviour:
- Interface: one clock, pixelClk. Reset is synchronous and active-high; reset is sampled only on the rising edge of pixelClk.
- Totals:
  - hTotal = hActive+hFront+hSyncW+hBack; vTotal = vActive+vFront+vSyncW+vBack.
  - Elaboration fails if either total exceeds 2^busWidth.
  - Elaboration fails if any porch or sync parameter is 0.
- Internal counters hPos (range 0..hTotal-1) and vPos (range 0..vTotal-1):
  - On an enabled edge, hPos increments.
  - At hPos==hTotal-1, hPos wraps to 0 and vPos increments.
  - At vPos==vTotal-1 with hPos==hTotal-1, both counters wrap to 0 on the same edge.
- Region decode, as a function of (h, v):
  - hSync asserted for h in [hActive+hFront, hActive+hFront+hSyncW-1].
  - vSync asserted for whole lines v in [vActive+vFront, vActive+vFront+vSyncW-1]. vSync changes only when the presented h is 0.
  - deOut = (h < hActive) && (v < vActive).
  - lineStart = (h == 0); frameStart = (h == 0) && (v == 0).
- Output registration and latency:
  - Every output is registered.
  - Outputs at edge N present the decode of (hPos, vPos) as held before edge N, i.e. one cycle of latency.
  - hCount/vCount are delayed identically, so all outputs always describe the same pixel.
- Reset:
  - Outputs go to: hCount=0, vCount=0, deOut=0, lineStart=0, frameStart=0, hSync=~hSyncPol, vSync=~vSyncPol.
  - Internal counters go to hPos=0, vPos=0.
  - The first enabled edge after reset presents (0,0): deOut=1, lineStart=1, frameStart=1.
- Reset mid-frame returns to the reset state on the next edge. There is no partial line.
- Reset has priority over enable.
- enable low: counters and all outputs hold their values, including pulse outputs. Sinks must qualify pulses with enable.
- Arithmetic is unsigned, busWidth wide. Region bounds are elaboration-time constants; no runtime adders on bounds.

Decomposition:
- Package video_timing_pkg holds:
  - constants for 1080p60 (1920/88/44/148, 1080/4/5/36; totals 2200 x 1125) and 720p60 (1280/110/40/220, 720/5/5/20);
  - a function that computes total from active/front/sync/back, used in the elaboration checks.
- Sub-module timing_axis_counter:
  - one axis counter plus region decode, parametrised by active/front/sync/back;
  - has an advance input and a wrap output;
  - instantiated twice: the horizontal axis advances on enable, the vertical axis advances on horizontal wrap && enable.

Test Plan:
All scenarios use the small configuration H=8/2/3/2 (hTotal=15) and V=4/1/2/1 (vTotal=8), with polarities 1 and enable held high unless stated.
1. Release reset -> first edge presents hCount=0, vCount=0, deOut=1, lineStart=1, frameStart=1; hCount reaches 14 on the 15th edge, then wraps to 0 with vCount=1.
2. Count one line -> deOut high for hCount 0..7; hSync high exactly for hCount 10..12; lineStart high only at hCount 0.
3. Count a full frame (120 edges) -> vSync high for vCount 5..6 and rising when hCount==0; deOut low for all vCount 4..7; after (14,7), the next edge presents (0,0) with frameStart=1.
4. Drive enable low for 5 cycles at hCount=3, vCount=2 -> all outputs frozen; counting resumes at hCount=4.
5. Assert reset at hCount=11, vCount=5 with enable high -> next edge: counts 0, deOut=0, hSync=0, vSync=0; reset with enable low behaves identically.
6. Run with hSyncPol=0, vSyncPol=0 -> both sync outputs idle high and go low only in the windows of scenarios 2 and 3; run 1080p60 package constants for one frame -> exactly 2200*1125 edges between frameStart pulses.
